onewire_master_avalon: RTL and testbench

- 1-Wire bus master with a single 32-bit Avalon-MM slave register.
- The CPU writes a command: a reset/presence cycle or a single bit time-slot.
- The block drives the open-drain line, samples the response and raises a completion status bit that the CPU polls, or an optional interrupt.
- Sits between the system Avalon interconnect and an external pulled-up 1-Wire pin.

---
 rtl/onewire_master_avalon.sv | 208 ++++++++++++++++++++
 tb/tb_onewire_master_avalon.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/onewire_master_avalon.sv
// onewire_master_avalon
//   1-Wire bus master behind a single 32-bit Avalon-MM slave register.
//   A CPU write starts either a reset/presence cycle or one bit time slot.
//   The block drives the open-drain line, samples the response and sets a
//   completion flag (CMP) that the CPU polls. It can also raise an optional
//   interrupt.
//
//   Optional feature macro: ONEWIRE_IRQ_EN
//     defined   : avalon_interrupt = registered CMP & IE, IE readable.
//     undefined : avalon_interrupt tied 0, IE reads as 0.
//
// Parameters
//   DVN  clk cycles per 6 us base tick T (144 at 24 MHz)
//   DVW  divider counter width, 2**DVW > DVN
//
// Ports
//   clk                 system clock
//   rst                 asynchronous reset, active low
//   avalon_read         register read strobe (no side effects)
//   avalon_write        register write strobe, command word
//   avalon_writedata    bit0 DAT, bit1 RST, bit5 IE, others ignored
//   avalon_readdata     bit0 sampled line, bit1 RST, bit4 CMP, bit5 IE, bit8 BSY
//   avalon_waitrequest  tied 0
//   avalon_interrupt    completion interrupt
//   onewire             open-drain bus, driven 0 or high-Z only
//
// Handshake: avalon_waitrequest is permanently low, so every read or write is
// complete in the cycle its strobe is high. avalon_readdata is combinational
// from registers, so a read in the same cycle as a write returns the state
// from before the write. A write while busy is accepted on the bus but ignored.
module onewire_master_avalon #(
  parameter int DVN = 144,
  parameter int DVW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        avalon_read,
  input  logic        avalon_write,
  input  logic [31:0] avalon_writedata,
  output logic [31:0] avalon_readdata,
  output logic        avalon_waitrequest,
  output logic        avalon_interrupt,
  inout  wire         onewire
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RESET_LOW  = 3'd1;
  localparam logic [2:0] RESET_WAIT = 3'd2;
  localparam logic [2:0] BIT_LOW    = 3'd3;
  localparam logic [2:0] BIT_WAIT   = 3'd4;

  localparam logic [DVW-1:0] DIV_LAST = DVW'(DVN - 1);

  logic [2:0]     state;
  logic [DVW-1:0] div_cnt;
  logic [7:0]     tick_cnt;
  logic           dat_q;
  logic           cmd_rst_q;
  logic           cmp_q;
  logic           bit_q;
  logic           drive_q;
  logic [1:0]     sync_q;
  logic [1:0]     samp_d;
  logic           ie_bit;

  logic tick;
  logic busy;
  logic wr_acc;
  logic samp_req;
  logic [7:0] bit_low_last;

  assign busy         = (state != IDLE);
  assign wr_acc       = avalon_write && !busy;
  assign tick         = busy && (div_cnt == DIV_LAST);
  assign bit_low_last = dat_q ? 8'd0 : 8'd9;

  // Sample strobe at the tick that marks the sample point. It is delayed by the
  // synchronizer depth so that the captured value is the line at that tick.
  // Bit slot: tick_cnt counts from slot start across BIT_LOW and BIT_WAIT, so
  // for DAT=0 the strobe falls while the master still holds the line low.
  always_comb begin
    samp_req = 1'b0;
    if (tick) begin
      if (state == RESET_WAIT && tick_cnt == 8'd11)
        samp_req = 1'b1;
      if ((state == BIT_LOW || state == BIT_WAIT) && tick_cnt == 8'd1)
        samp_req = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      dat_q     <= 1'b0;
      cmd_rst_q <= 1'b0;
      cmp_q     <= 1'b0;
      bit_q     <= 1'b0;
      drive_q   <= 1'b0;
      sync_q    <= 2'b11;
      samp_d    <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], onewire};
      samp_d <= {samp_d[0], samp_req};
      if (samp_d[1])
        bit_q <= sync_q[1];

      if (!busy || tick)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (wr_acc) begin
            dat_q     <= avalon_writedata[0];
            cmd_rst_q <= avalon_writedata[1];
            cmp_q     <= 1'b0;
            tick_cnt  <= '0;
            drive_q   <= 1'b1;
            state     <= avalon_writedata[1] ? RESET_LOW : BIT_LOW;
          end
        end
        RESET_LOW: begin
          if (tick) begin
            if (tick_cnt == 8'd79) begin
              tick_cnt <= '0;
              drive_q  <= 1'b0;
              state    <= RESET_WAIT;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        RESET_WAIT: begin
          if (tick) begin
            if (tick_cnt == 8'd79) begin
              cmp_q <= 1'b1;
              state <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        BIT_LOW: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == bit_low_last) begin
              drive_q <= 1'b0;
              state   <= BIT_WAIT;
            end
          end
        end
        BIT_WAIT: begin
          // 11 T slot including recovery time.
          if (tick) begin
            if (tick_cnt == 8'd10) begin
              cmp_q <= 1'b1;
              state <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          drive_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef ONEWIRE_IRQ_EN
  logic ie_q;
  logic irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_acc)
        ie_q <= avalon_writedata[5];
      // The accepted write drops the interrupt on the same edge that clears CMP.
      irq_q <= wr_acc ? 1'b0 : (cmp_q & ie_q);
    end
  end

  assign ie_bit           = ie_q;
  assign avalon_interrupt = irq_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, avalon_read, avalon_writedata[31:6], avalon_writedata[4:2]};
`else
  assign ie_bit           = 1'b0;
  assign avalon_interrupt = 1'b0;

  logic unused_bits;
  assign unused_bits = &{1'b0, avalon_read, avalon_writedata[31:2]};
`endif

  assign avalon_waitrequest = 1'b0;
  assign avalon_readdata    = {23'd0, busy, 2'b00, ie_bit, cmp_q, 2'b00, cmd_rst_q, bit_q};

  assign onewire = drive_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_onewire_master_avalon.sv
module tb_onewire_master_avalon;

  localparam int DVN = 12;
  localparam int DVW = 8;

`ifdef ONEWIRE_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        avalon_read = 1'b0;
  logic        avalon_write = 1'b0;
  logic [31:0] avalon_writedata = '0;
  logic [31:0] avalon_readdata;
  logic        avalon_waitrequest;
  logic        avalon_interrupt;
  wire         onewire;
  logic        slave_low = 1'b0;

  assign onewire = slave_low ? 1'b0 : 1'bz;
  pullup (onewire);

  onewire_master_avalon #(.DVN(DVN), .DVW(DVW)) dut (
    .clk                (clk),
    .rst                (rst),
    .avalon_read        (avalon_read),
    .avalon_write       (avalon_write),
    .avalon_writedata   (avalon_writedata),
    .avalon_readdata    (avalon_readdata),
    .avalon_waitrequest (avalon_waitrequest),
    .avalon_interrupt   (avalon_interrupt),
    .onewire            (onewire)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_status = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Slave behaviour, c = clk cycles since the command write was accepted.
  // mode 0: silent; 1: presence pulse 30..150 us after a 480 us reset pulse;
  // mode 2: holds the line low for the first 24 us of a slot (reads as 0).
  function automatic bit slave_low_at(input int mode, input int c);
    if (mode == 1) return (c >= 85 * DVN) && (c < 105 * DVN);
    if (mode == 2) return (c < 4 * DVN);
    return 1'b0;
  endfunction

  // Reference model: status word expected once the command completes.
  function automatic logic [31:0] model_status(input logic [31:0] cmd, input int mode);
    int          low_t;
    int          samp_t;
    int          c;
    bit          line_low;
    logic [31:0] s;
    low_t    = cmd[1] ? 80 : (cmd[0] ? 1 : 10);
    samp_t   = cmd[1] ? 92 : 2;            // reset: 12 T after the 80 T pulse
    c        = samp_t * DVN - 1;
    line_low = (c < low_t * DVN) || slave_low_at(mode, c);
    s        = '0;
    s[0]     = !line_low;
    s[1]     = cmd[1];
    s[4]     = 1'b1;
    s[5]     = IRQ & cmd[5];
    return s;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic run_cmd(input logic [31:0] cmd, input int mode, input int busy_k);
    int  low_t;
    int  total_t;
    int  k;
    int  low_run;
    bit  in_run;
    low_t   = cmd[1] ? 80 : (cmd[0] ? 1 : 10);
    total_t = cmd[1] ? 160 : 11;
    exp_q.push_back(model_status(cmd, mode));

    @(negedge clk);
    avalon_write     = 1'b1;
    avalon_writedata = cmd;
    avalon_read      = 1'b1;
    #1;
    check("pre_write_read", avalon_readdata, last_status);
    @(negedge clk);
    avalon_write = 1'b0;
    avalon_read  = 1'b0;

    low_run = 0;
    in_run  = 1'b1;
    for (k = 0; k <= total_t * DVN + 50; k++) begin
      slave_low = slave_low_at(mode, k);
      if (busy_k > 0 && k == busy_k) begin
        avalon_write     = 1'b1;
        avalon_writedata = 32'h0000_0002;
      end
      if (busy_k > 0 && k == busy_k + 1)
        avalon_write = 1'b0;
      #1;
      if (k == 0)
        check("irq_clear_on_write", {31'd0, avalon_interrupt}, 32'd0);
      if (in_run && onewire === 1'b0) low_run++;
      else in_run = 1'b0;
      if (k == DVN)
        check("busy_status", avalon_readdata & 32'h110, 32'h100);
      if (avalon_readdata[4]) break;
      @(negedge clk);
    end
    slave_low    = 1'b0;
    avalon_write = 1'b0;

    check("done_cycles", k, total_t * DVN);
    if (mode != 2)
      check("low_cycles", low_run, low_t * DVN);
    last_status = exp_q.pop_front();
    check("status", avalon_readdata, last_status);
    check("waitrequest", {31'd0, avalon_waitrequest}, 32'd0);

    @(negedge clk);
    #1;
    check("irq", {31'd0, avalon_interrupt}, {31'd0, IRQ & cmd[5]});

    repeat (2 * DVN) @(negedge clk);
    #1;
    check("idle_after", {30'd0, onewire, avalon_readdata[8]}, 32'd2);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] cmd;
    int          mode;

    repeat (2) @(negedge clk);
    #1;
    check("reset_line", {31'd0, onewire}, 32'd1);
    check("reset_readdata", avalon_readdata, 32'd0);
    check("reset_irq", {31'd0, avalon_interrupt}, 32'd0);
    check("reset_waitreq", {31'd0, avalon_waitrequest}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_cmd(32'h0000_0002, 1, 0);   // reset with presence
    run_cmd(32'h0000_0000, 0, 0);   // write 0
    run_cmd(32'h0000_0001, 0, 0);   // read slot, slave releases
    run_cmd(32'h0000_0001, 2, 0);   // read slot, slave holds low
    run_cmd(32'h0000_0000, 0, 20);  // busy write 10 us into the slot
    run_cmd(32'h0000_0020, 0, 0);   // interrupt enabled
    run_cmd(32'h0000_0002, 0, 0);   // reset without presence

    for (int i = 0; i < 10; i++) begin
      cmd    = $urandom;
      cmd[1] = ($urandom_range(0, 3) == 0);
      if (cmd[1]) mode = $urandom_range(0, 1);
      else        mode = 2 * $urandom_range(0, 1);
      run_cmd(cmd, mode, 0);
    end

    // Reset in the middle of a reset pulse aborts and releases the bus.
    @(negedge clk);
    avalon_write     = 1'b1;
    avalon_writedata = 32'h0000_0022;
    @(negedge clk);
    avalon_write = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    check("mid_line_low", {31'd0, onewire}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_line", {31'd0, onewire}, 32'd1);
    check("abort_readdata", avalon_readdata, 32'd0);
    check("abort_irq", {31'd0, avalon_interrupt}, 32'd0);
    repeat (2) @(negedge clk);
    rst         = 1'b1;
    last_status = '0;
    run_cmd(32'h0000_0001, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
